// File: rtl/sb_cfg_pkg.sv
// Shared select codes, config FSM states and config-length helper for the switch block.
package sb_cfg_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_OFF      = 2'd0;
  localparam logic [SEL_W-1:0] SEL_STRAIGHT = 2'd1;
  localparam logic [SEL_W-1:0] SEL_ALT      = 2'd2;
  localparam logic [SEL_W-1:0] SEL_PIN      = 2'd3;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2,
    OVER    = 2'd3
  } cfg_state_t;

  // Three output sides, CHAN_W tracks each, SEL_W bits per track mux.
  function automatic int cfg_len(input int chan_w);
    return 3 * SEL_W * chan_w;
  endfunction

endpackage

// File: rtl/sb_track_mux.sv
// One routing-track 4:1 mux; code SEL_OFF drives 0.
// Purely combinational, no flow control.
module sb_track_mux
  import sb_cfg_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             straight_in,
  input  logic             alt_in,
  input  logic             pin_in,
  output logic             track_out
);

  always_comb begin
    track_out = 1'b0;
    case (sel)
      SEL_OFF:      track_out = 1'b0;
      SEL_STRAIGHT: track_out = straight_in;
      SEL_ALT:      track_out = alt_in;
      SEL_PIN:      track_out = pin_in;
      default:      track_out = 1'b0;
    endcase
  end

endmodule

// File: rtl/sb_param_cfg.sv
// Parametrised switch block (top/right/left) with a double-buffered serial config store;
// routing is combinational from the active register, no backpressure. Optional: SB_CFG_PARITY_EN.
module sb_param_cfg
  import sb_cfg_pkg::*;
#(
  parameter int CHAN_W = 5,
  parameter int N_PIN  = 1
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              ccff_head,
  input  logic              cfg_shift_en,
  input  logic              cfg_commit,
  output logic              ccff_tail,
  output logic              cfg_active,
  output logic              cfg_err,
  input  logic [CHAN_W-1:0] chany_top_in,
  input  logic [CHAN_W-1:0] chanx_right_in,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [N_PIN-1:0]  top_pin,
  input  logic [N_PIN-1:0]  right_pin,
  input  logic [N_PIN-1:0]  left_pin,
  output logic [CHAN_W-1:0] chany_top_out,
  output logic [CHAN_W-1:0] chanx_right_out,
  output logic [CHAN_W-1:0] chanx_left_out
);

  localparam int NB = cfg_len(CHAN_W);
`ifdef SB_CFG_PARITY_EN
  localparam int SR_LEN = NB + 1;
`else
  localparam int SR_LEN = NB;
`endif
  // Counter must reach SR_LEN+1 (overflow marker) without wrapping.
  localparam int CNT_W = $clog2(SR_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(SR_LEN + 1);

  logic [SR_LEN-1:0] sr_q, sr_d;
  logic [NB-1:0]     active_q, active_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cfg_state_t        state_q, state_d;
  logic              cfg_active_q, cfg_active_d;
  logic              cfg_err_q, cfg_err_d;
  logic              parity_ok;
  logic              commit_ok;
  logic              commit_rej;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q      <= EMPTY;
      cnt_q        <= '0;
      sr_q         <= '0;
      active_q     <= '0;
      cfg_active_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      active_q     <= active_d;
      cfg_active_q <= cfg_active_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  always_comb begin : p_next
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cfg_shift_en && (cnt_q != CNT_OVF)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      EMPTY:   if (cfg_shift_en) state_d = LOADING;
      LOADING: if (cfg_shift_en && (cnt_q == CNT_LAST)) state_d = FULL;
      FULL:    if (cfg_shift_en) state_d = OVER;
      OVER:    state_d = OVER;
      default: state_d = EMPTY;
    endcase
    // An accepted commit restarts the count; a same-cycle shift is the first new bit.
    if (commit_ok) begin
      state_d = cfg_shift_en ? LOADING : EMPTY;
      cnt_d   = cfg_shift_en ? CNT_W'(1) : '0;
    end
  end

  // Commit is judged on pre-shift state and chain contents.
  always_comb begin : p_commit
    parity_ok = 1'b1;
`ifdef SB_CFG_PARITY_EN
    parity_ok = ~(^sr_q);
`endif
    commit_ok  = cfg_commit && (state_q == FULL) && parity_ok;
    commit_rej = cfg_commit && !commit_ok;
  end

  always_comb begin : p_data
    sr_d         = sr_q;
    active_d     = active_q;
    cfg_active_d = cfg_active_q;
    cfg_err_d    = cfg_err_q;
    if (cfg_shift_en) begin
      sr_d = {sr_q[SR_LEN-2:0], ccff_head};
    end
    if (commit_ok) begin
      active_d     = sr_q[NB-1:0];
      cfg_active_d = 1'b1;
      cfg_err_d    = 1'b0;
    end else if (commit_rej) begin
      cfg_err_d = 1'b1;
    end
  end

  assign ccff_tail  = sr_q[SR_LEN-1];
  assign cfg_active = cfg_active_q;
  assign cfg_err    = cfg_err_q;

  // Mux k uses active_q[2k+1:2k]; k runs top, then right, then left.
  for (genvar t = 0; t < CHAN_W; t++) begin : g_trk
    sb_track_mux u_top (
      .sel        (active_q[SEL_W*t +: SEL_W]),
      .straight_in(chanx_right_in[t]),
      .alt_in     (chanx_left_in[t]),
      .pin_in     (top_pin[t % N_PIN]),
      .track_out  (chany_top_out[t])
    );
    sb_track_mux u_right (
      .sel        (active_q[SEL_W*(CHAN_W+t) +: SEL_W]),
      .straight_in(chanx_left_in[t]),
      .alt_in     (chany_top_in[t]),
      .pin_in     (right_pin[t % N_PIN]),
      .track_out  (chanx_right_out[t])
    );
    sb_track_mux u_left (
      .sel        (active_q[SEL_W*(2*CHAN_W+t) +: SEL_W]),
      .straight_in(chanx_right_in[t]),
      .alt_in     (chany_top_in[(t+1) % CHAN_W]),
      .pin_in     (left_pin[t % N_PIN]),
      .track_out  (chanx_left_out[t])
    );
  end

endmodule

// File: tb/tb_sb_param_cfg.sv
// Scoreboard bench for sb_param_cfg: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_sb_param_cfg;

  localparam int CW = 5;
  localparam int NB = 30;
`ifdef SB_CFG_PARITY_EN
  localparam int SR_LEN = NB + 1;
`else
  localparam int SR_LEN = NB;
`endif

  localparam logic [CW-1:0] T1 = 5'b10110, R1 = 5'b01101, L1 = 5'b11010;
  localparam logic [CW-1:0] T2 = 5'b01001, R2 = 5'b10011, L2 = 5'b00111;
  localparam logic [CW-1:0] Z  = 5'b00000;
  // Every select = 1: top<-right_in, right<-left_in, left<-right_in.
  localparam logic [NB-1:0] W_ALL1 = 30'h15555555;
  // Top selects = PIN, right/left selects = ALT.
  localparam logic [NB-1:0] W_MIX  = 30'h2AAAABFF;
  localparam logic [CW-1:0] MIX_TOP1  = 5'b11111;  // top_pin=1
  localparam logic [CW-1:0] MIX_LEFT1 = 5'b01011;  // left[t]=T1[(t+1)%5]

  logic          prog_clk = 1'b0;
  logic          pReset_n, ccff_head, cfg_shift_en, cfg_commit;
  logic          ccff_tail, cfg_active, cfg_err;
  logic [CW-1:0] chany_top_in, chanx_right_in, chanx_left_in;
  logic [0:0]    top_pin, right_pin, left_pin;
  logic [CW-1:0] chany_top_out, chanx_right_out, chanx_left_out;

  sb_param_cfg #(.CHAN_W(CW), .N_PIN(1)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .ccff_head(ccff_head),
    .cfg_shift_en(cfg_shift_en), .cfg_commit(cfg_commit), .ccff_tail(ccff_tail),
    .cfg_active(cfg_active), .cfg_err(cfg_err),
    .chany_top_in(chany_top_in), .chanx_right_in(chanx_right_in), .chanx_left_in(chanx_left_in),
    .top_pin(top_pin), .right_pin(right_pin), .left_pin(left_pin),
    .chany_top_out(chany_top_out), .chanx_right_out(chanx_right_out), .chanx_left_out(chanx_left_out)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct packed {
    logic [CW-1:0] top;
    logic [CW-1:0] right;
    logic [CW-1:0] left;
    logic          act;
    logic          err;
    logic          tail;
    logic          tail_chk;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  logic  chk_vld = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic exp_t mk(input logic [CW-1:0] t, input logic [CW-1:0] r, input logic [CW-1:0] l,
                              input logic a, input logic e, input logic tl, input logic tc);
    exp_t x;
    x.top = t; x.right = r; x.left = l; x.act = a; x.err = e; x.tail = tl; x.tail_chk = tc;
    return x;
  endfunction

  task automatic cmp(input string nm, input string fld, input logic [CW-1:0] act_v, input logic [CW-1:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s.%s: got %b, expected %b", nm, fld, act_v, exp_v);
    end
  endtask

  // Monitor: pops one expectation for every check strobe.
  always @(negedge prog_clk) begin
    exp_t  e;
    string nm;
    if (chk_vld) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        cmp(nm, "top_out",   chany_top_out,   e.top);
        cmp(nm, "right_out", chanx_right_out, e.right);
        cmp(nm, "left_out",  chanx_left_out,  e.left);
        cmp(nm, "cfg_active", {4'b0, cfg_active}, {4'b0, e.act});
        cmp(nm, "cfg_err",    {4'b0, cfg_err},    {4'b0, e.err});
        if (e.tail_chk) cmp(nm, "ccff_tail", {4'b0, ccff_tail}, {4'b0, e.tail});
      end
    end
  end

  task automatic expect_out(input string nm, input exp_t e);
    sb_q.push_back(e);
    nm_q.push_back(nm);
    chk_vld = 1'b1;
    @(negedge prog_clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_shift_en = 1'b1;
    ccff_head    = b;
    tick();
    cfg_shift_en = 1'b0;
    ccff_head    = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic set_in(input logic [CW-1:0] t, input logic [CW-1:0] r, input logic [CW-1:0] l, input logic p);
    chany_top_in = t; chanx_right_in = r; chanx_left_in = l;
    top_pin = p; right_pin = ~p; left_pin = p;
  endtask

  function automatic logic [SR_LEN-1:0] stream(input logic [NB-1:0] w);
    logic [SR_LEN-1:0] s;
    s = '0;
    s[NB-1:0] = w;
`ifdef SB_CFG_PARITY_EN
    s[NB] = ^w;
`endif
    return s;
  endfunction

  // Shift stream bits [from, to) counted from the MSB (first bit out of the head).
  task automatic shift_stream(input logic [SR_LEN-1:0] s, input int from, input int to);
    for (int i = from; i < to; i++) shift_bit(s[SR_LEN-1-i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected one within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SR_LEN-1:0] s;
    pReset_n = 1'b0; ccff_head = 1'b0; cfg_shift_en = 1'b0; cfg_commit = 1'b0;
    set_in(Z, Z, Z, 1'b0);
    tick(); tick();

    // Reset with inputs toggled: nothing routes.
    set_in(T1, R1, L1, 1'b1);
    expect_out("in_reset", mk(Z, Z, Z, 0, 0, 0, 1));
    tick();
    pReset_n = 1'b1;
    tick();
    expect_out("post_reset_a", mk(Z, Z, Z, 0, 0, 0, 1));
    set_in(T2, R2, L2, 1'b0);
    expect_out("post_reset_b", mk(Z, Z, Z, 0, 0, 0, 1));
    set_in(T1, R1, L1, 1'b1);

    // Full load of all-ones selects; chain alone must not route.
    tick();
    shift_stream(stream(W_ALL1), 0, SR_LEN);
    expect_out("all1_pre_commit", mk(Z, Z, Z, 0, 0, 0, 0));
    commit();
    expect_out("all1_commit", mk(R1, L1, R1, 1, 0, 0, 0));
    set_in(T2, R2, L2, 1'b0);
    expect_out("all1_inputs2", mk(R2, L2, R2, 1, 0, 0, 0));
    set_in(T1, R1, L1, 1'b1);

    // One bit short: rejected, then the final bit makes it acceptable.
    tick();
    shift_stream(stream(W_MIX), 0, SR_LEN - 1);
    commit();
    expect_out("short_commit_rej", mk(R1, L1, R1, 1, 1, 0, 0));
    tick();
    shift_stream(stream(W_MIX), SR_LEN - 1, SR_LEN);
    commit();
    expect_out("full_commit_ok", mk(MIX_TOP1, T1, MIX_LEFT1, 1, 0, 0, 0));

    // Overflow: first new bit 0 then ones; the 0 reaches the tail after SR_LEN shifts.
    tick();
    shift_bit(1'b0);
    for (int i = 1; i < SR_LEN - 1; i++) shift_bit(1'b1);
    expect_out("tail_before", mk(MIX_TOP1, T1, MIX_LEFT1, 1, 0, 1, 1));
    tick();
    shift_bit(1'b1);
    expect_out("tail_first_bit", mk(MIX_TOP1, T1, MIX_LEFT1, 1, 0, 0, 1));
    tick();
    shift_bit(1'b1);
    expect_out("tail_second_bit", mk(MIX_TOP1, T1, MIX_LEFT1, 1, 0, 1, 1));
    tick();
    commit();
    expect_out("over_commit_rej", mk(MIX_TOP1, T1, MIX_LEFT1, 1, 1, 1, 1));

    // Reset in the middle of the 13th shift clears everything.
    tick();
    shift_stream(stream(W_ALL1), 0, 12);
    expect_out("pre_midreset", mk(MIX_TOP1, T1, MIX_LEFT1, 1, 1, 0, 0));
    tick();
    cfg_shift_en = 1'b1;
    ccff_head    = 1'b1;
    #2;
    pReset_n = 1'b0;
    expect_out("midreset", mk(Z, Z, Z, 0, 0, 0, 1));
    cfg_shift_en = 1'b0;
    tick();
    pReset_n = 1'b1;
    tick();
    expect_out("after_midreset", mk(Z, Z, Z, 0, 0, 0, 1));
    tick();
    shift_stream(stream(W_ALL1), 0, SR_LEN);
    commit();
    expect_out("reload_after_reset", mk(R1, L1, R1, 1, 0, 0, 0));

    // Reshift without commit: old routing holds every cycle, then switches on commit.
    s = stream(W_MIX);
    for (int i = 0; i < SR_LEN; i++) begin
      tick();
      shift_bit(s[SR_LEN-1-i]);
      expect_out("hold_old_route", mk(R1, L1, R1, 1, 0, 0, 0));
    end
    tick();
    commit();
    expect_out("switch_on_commit", mk(MIX_TOP1, T1, MIX_LEFT1, 1, 0, 0, 0));

    // Commit straight after reset (EMPTY) is rejected.
    tick();
    pReset_n = 1'b0;
    tick();
    pReset_n = 1'b1;
    tick();
    commit();
    expect_out("empty_commit_rej", mk(Z, Z, Z, 0, 1, 0, 0));

`ifdef SB_CFG_PARITY_EN
    // Bad parity on an otherwise full chain is rejected; good parity is accepted.
    tick();
    pReset_n = 1'b0;
    tick();
    pReset_n = 1'b1;
    tick();
    s = stream(W_ALL1);
    s[NB] = ~s[NB];
    shift_stream(s, 0, SR_LEN);
    commit();
    expect_out("parity_bad_rej", mk(Z, Z, Z, 0, 1, 0, 0));
    tick();
    pReset_n = 1'b0;
    tick();
    pReset_n = 1'b1;
    tick();
    shift_stream(stream(W_ALL1), 0, SR_LEN);
    commit();
    expect_out("parity_good_ok", mk(R1, L1, R1, 1, 0, 0, 0));
`endif

    tick();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
